// File: rtl/tinyyolov3_ctrl_master_if.sv
// tinyyolov3_ctrl_master_if: AXI4-Lite control-port bundle between layer master and kernel slave
interface tinyyolov3_ctrl_master_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rvalid;
  logic                  rready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/tinyyolov3_ctrl_master.sv
// tinyyolov3_ctrl_master: writes one layer's config words plus ap_start, then polls AP_CTRL for ap_done
module tinyyolov3_ctrl_master #(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_CFG    = 11,
  parameter int CFG_BASE   = 'h10,
  parameter int CFG_STRIDE = 8,
  parameter int POLL_GAP   = 16,
  parameter int TIMEOUT    = 2**20
) (
  input  logic                    ap_clk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [NUM_CFG*32-1:0]   cmd_cfg,
  tinyyolov3_ctrl_master_if.master m_axi,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_code
);
  localparam int IW = $clog2(NUM_CFG + 1);
  localparam int GW = $clog2(POLL_GAP + 1);
  typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RRESP, GAP, FIN, ABORT} state_t;
  state_t                state_q, state_d;
  logic [NUM_CFG*32-1:0] cfg_q, cfg_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  aw_q, aw_d, w_q, w_d;
  logic [31:0]           timer_q, timer_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [1:0]            err_q, err_d;
  logic                  start_ph;
  logic                  unused_rdata;
  // idx == NUM_CFG selects the final ap_start write to AP_CTRL
  assign start_ph       = idx_q == IW'(NUM_CFG);
  assign unused_rdata   = ^{m_axi.rdata[31:2], m_axi.rdata[0]};
  assign m_axi.awvalid  = aw_q;
  assign m_axi.wvalid   = w_q;
  assign m_axi.awaddr   = start_ph ? '0 : ADDR_WIDTH'(CFG_BASE + CFG_STRIDE * int'(idx_q));
  assign m_axi.wdata    = start_ph ? 32'h1 : cfg_q[32*idx_q +: 32];
  assign m_axi.wstrb    = 4'hF;
  assign m_axi.bready   = state_q == WRESP;
  assign m_axi.arvalid  = state_q == RD;
  assign m_axi.araddr   = '0;
  assign m_axi.rready   = state_q == RRESP;
  assign cmd_ready      = state_q == IDLE;
  assign busy           = state_q != IDLE;
  assign done           = state_q == FIN;
  assign error          = state_q == ABORT;
  assign err_code       = err_q;
  // next-state: write sequencing, response checks, poll pacing and timeout
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    idx_d   = idx_q;
    aw_d    = aw_q;
    w_d     = w_q;
    timer_d = state_q inside {RD, RRESP, GAP} ? timer_q + 32'd1 : timer_q;
    gap_d   = gap_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        cfg_d   = cmd_cfg;
        idx_d   = '0;
        err_d   = 2'd0;
        aw_d    = 1'b1;
        w_d     = 1'b1;
        state_d = WR;
      end
      WR: begin
        aw_d = aw_q & ~m_axi.awready;
        w_d  = w_q & ~m_axi.wready;
        if (!aw_d && !w_d) state_d = WRESP;
      end
      WRESP: if (m_axi.bvalid) begin
        if (m_axi.bresp != 2'b00) begin
          err_d   = 2'd1;
          state_d = ABORT;
        end else if (!start_ph) begin
          idx_d   = idx_q + IW'(1);
          aw_d    = 1'b1;
          w_d     = 1'b1;
          state_d = WR;
        end else begin
          timer_d = '0;
          state_d = RD;
        end
      end
      RD: if (m_axi.arready) state_d = RRESP;
      RRESP: if (m_axi.rvalid) begin
        if (m_axi.rresp != 2'b00) begin
          err_d   = 2'd2;
          state_d = ABORT;
        end else if (m_axi.rdata[1]) state_d = FIN;
        else begin
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (TIMEOUT != 0 && timer_q >= 32'(TIMEOUT)) begin
          err_d   = 2'd3;
          state_d = ABORT;
        end else if (gap_q == GW'(POLL_GAP - 1)) state_d = RD;
        else gap_d = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset abandons any in-flight transfer
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      idx_q   <= '0;
      aw_q    <= 1'b0;
      w_q     <= 1'b0;
      timer_q <= '0;
      gap_q   <= '0;
      err_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      idx_q   <= idx_d;
      aw_q    <= aw_d;
      w_q     <= w_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_tinyyolov3_ctrl_master.sv
// tb_tinyyolov3_ctrl_master: scoreboard bench with a reactive AXI4-Lite slave model
module tb_tinyyolov3_ctrl_master;
  typedef struct {logic [11:0] a; logic [31:0] d;} wr_t;
  logic          ap_clk, areset, cmd_valid, cmd_ready, busy, done, error;
  logic [351:0]  cmd_cfg;
  logic [1:0]    err_code;
  tinyyolov3_ctrl_master_if #(.ADDR_WIDTH(12)) m_axi();
  tinyyolov3_ctrl_master #(.TIMEOUT(200)) dut (
    .ap_clk(ap_clk), .areset(areset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_cfg(cmd_cfg), .m_axi(m_axi), .busy(busy), .done(done), .error(error),
    .err_code(err_code)
  );
  int  total = 0, bad = 0;
  wr_t exp_q[$];
  int  ar_cyc[$];
  int  cyc = 0, wr_n = 0, rd_n = 0, dn_cnt = 0, er_cnt = 0, err_cyc = 0;
  int  wr0, rd0, dn0, er0;
  int  aw_lat, w_lat, bresp_at, done_at;
  int  aw_wait = 0, w_wait = 0;
  logic have_aw = 0, have_w = 0, b_fire = 0, r_fire = 0, r_pend = 0;
  logic [11:0] got_a;
  logic [31:0] got_d;
  logic [3:0]  got_s;
  wr_t e;
  initial ap_clk = 0;
  always #5 ap_clk = ~ap_clk;
  initial begin
    #500000;
    $display("FAIL watchdog: no summary after 50000 cycles");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ap_clk);
      #2;
    end
  endtask
  // slave model and monitor: responds at negedge, pops the scoreboard on each complete write
  always @(negedge ap_clk) begin
    cyc++;
    if (areset) begin
      m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0; m_axi.bresp = 0;
      m_axi.arready = 0; m_axi.rvalid = 0; m_axi.rdata = 0; m_axi.rresp = 0;
      have_aw = 0; have_w = 0; b_fire = 0; r_fire = 0; r_pend = 0; aw_wait = 0; w_wait = 0;
    end else begin
      if (done) dn_cnt++;
      if (error) begin
        er_cnt++;
        err_cyc = cyc;
        chk("abort_no_dangling_ar", 32'({m_axi.arvalid, m_axi.rready}), 0);
      end
      if (b_fire) begin m_axi.bvalid = 0; b_fire = 0; end
      if (have_aw && have_w) begin
        if (exp_q.size() == 0) chk("unexpected_write", 32'(got_a), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(got_a), 32'(e.a));
          chk("wr_data", got_d, e.d);
          chk("wr_strb", 32'(got_s), 32'hF);
        end
        wr_n++;
        m_axi.bvalid = 1;
        m_axi.bresp = (wr_n == bresp_at) ? 2'b10 : 2'b00;
        have_aw = 0; have_w = 0;
      end
      if (m_axi.bvalid && m_axi.bready) b_fire = 1;
      m_axi.awready = m_axi.awvalid && !have_aw && aw_wait >= aw_lat;
      aw_wait = (m_axi.awvalid && !m_axi.awready && !have_aw) ? aw_wait + 1 : 0;
      if (m_axi.awvalid && m_axi.awready) begin got_a = m_axi.awaddr; have_aw = 1; end
      m_axi.wready = m_axi.wvalid && !have_w && w_wait >= w_lat;
      w_wait = (m_axi.wvalid && !m_axi.wready && !have_w) ? w_wait + 1 : 0;
      if (m_axi.wvalid && m_axi.wready) begin got_d = m_axi.wdata; got_s = m_axi.wstrb; have_w = 1; end
      if (r_fire) begin m_axi.rvalid = 0; r_fire = 0; end
      m_axi.arready = m_axi.arvalid;
      if (m_axi.arvalid) begin
        chk("rd_addr", 32'(m_axi.araddr), 0);
        rd_n++;
        ar_cyc.push_back(cyc);
        r_pend = 1;
      end else if (r_pend && !m_axi.rvalid) begin
        m_axi.rvalid = 1;
        m_axi.rdata = (done_at != 0 && rd_n >= done_at) ? 32'h2 : 32'h0;
        m_axi.rresp = 0;
        r_pend = 0;
      end
      if (m_axi.rvalid && m_axi.rready) r_fire = 1;
    end
  end
  task automatic snap();
    wr0 = wr_n; rd0 = rd_n; dn0 = dn_cnt; er0 = er_cnt;
  endtask
  task automatic push_layer(input logic [31:0] base, input int n);
    wr_t x;
    for (int i = 0; i < n; i++) begin
      x.a = i < 11 ? 12'(16 + 8 * i) : 12'h0;
      x.d = i < 11 ? base + 32'(i) : 32'h1;
      exp_q.push_back(x);
    end
  endtask
  task automatic send_cmd(input logic [31:0] base);
    chk("cmd_ready_before_cmd", 32'(cmd_ready), 1);
    for (int i = 0; i < 11; i++) cmd_cfg[32*i +: 32] = base + 32'(i);
    cmd_valid = 1;
    tick(1);
    cmd_valid = 0;
    chk("busy_after_accept", 32'(busy), 1);
    chk("err_code_cleared", 32'(err_code), 0);
  endtask
  task automatic wait_end(input string nm);
    int k = 0;
    int n0 = dn_cnt + er_cnt;
    while (dn_cnt + er_cnt == n0 && k < 3000) begin
      tick(1);
      k++;
    end
    chk({nm, "_finished"}, 32'(k < 3000), 1);
  endtask
  task automatic end_checks(input string nm, input int nw, input int nr, input int nd, input int ne);
    chk({nm, "_writes"}, 32'(wr_n - wr0), 32'(nw));
    chk({nm, "_reads"}, 32'(rd_n - rd0), 32'(nr));
    chk({nm, "_done_pulses"}, 32'(dn_cnt - dn0), 32'(nd));
    chk({nm, "_err_pulses"}, 32'(er_cnt - er0), 32'(ne));
    chk({nm, "_queue_empty"}, 32'(exp_q.size()), 0);
    chk({nm, "_idle"}, 32'({cmd_ready, busy}), 32'b10);
  endtask
  initial begin
    int min_sp;
    int k;
    areset = 1; cmd_valid = 0; cmd_cfg = '0;
    aw_lat = 0; w_lat = 0; bresp_at = 0; done_at = 0;
    tick(2);
    areset = 0;
    tick(1);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pulses", 32'({done, error}), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_valids", 32'({m_axi.awvalid, m_axi.wvalid, m_axi.arvalid, m_axi.bready, m_axi.rready}), 0);
    // zero-latency slave, ap_done on first read
    snap(); done_at = rd_n + 1;
    push_layer(32'hA0, 12); send_cmd(32'hA0); wait_end("t1"); tick(3);
    end_checks("t1", 12, 1, 1, 0);
    chk("t1_err_code", 32'(err_code), 0);
    // wready three cycles ahead of awready
    snap(); done_at = rd_n + 1; aw_lat = 3; w_lat = 0;
    push_layer(32'h100, 12); send_cmd(32'h100); wait_end("t2"); tick(3);
    end_checks("t2", 12, 1, 1, 0);
    // address ahead of data
    snap(); done_at = rd_n + 1; aw_lat = 0; w_lat = 2;
    push_layer(32'h200, 12); send_cmd(32'h200); wait_end("t2b"); tick(3);
    end_checks("t2b", 12, 1, 1, 0);
    w_lat = 0;
    // ap_done on the fourth read
    snap(); done_at = rd_n + 4;
    push_layer(32'h300, 12); send_cmd(32'h300); wait_end("t3"); tick(3);
    end_checks("t3", 12, 4, 1, 0);
    min_sp = 1000;
    for (int i = rd0 + 1; i < rd_n; i++) if (ar_cyc[i] - ar_cyc[i-1] < min_sp) min_sp = ar_cyc[i] - ar_cyc[i-1];
    chk("t3_poll_spacing_ge17", 32'(min_sp >= 17), 1);
    // slave error response on fifth write
    snap(); done_at = 0; bresp_at = wr_n + 5;
    push_layer(32'h400, 5); send_cmd(32'h400); wait_end("t4"); tick(40);
    end_checks("t4", 5, 0, 0, 1);
    chk("t4_err_code", 32'(err_code), 1);
    chk("t4_no_aw_ar", 32'({m_axi.awvalid, m_axi.arvalid}), 0);
    bresp_at = 0;
    // ap_done never set: poll timeout
    snap(); done_at = 0;
    push_layer(32'h500, 12); send_cmd(32'h500); wait_end("t5"); tick(3);
    end_checks("t5", 12, rd_n - rd0, 0, 1);
    chk("t5_err_code", 32'(err_code), 3);
    chk("t5_some_reads", 32'(rd_n - rd0 >= 2), 1);
    if (rd_n > rd0) chk("t5_timeout_window", 32'(err_cyc - ar_cyc[rd0] >= 200 && err_cyc - ar_cyc[rd0] <= 220), 1);
    // reset during the seventh write, then a clean layer
    snap(); done_at = rd_n + 1; aw_lat = 3;
    push_layer(32'h600, 12); send_cmd(32'h600);
    k = 0;
    while (!(wr_n - wr0 == 6 && m_axi.awvalid) && k < 500) begin tick(1); k++; end
    chk("t6_reached_write7", 32'(k < 500), 1);
    areset = 1;
    tick(1);
    areset = 0;
    chk("t6_valids_cleared", 32'({m_axi.awvalid, m_axi.wvalid, m_axi.arvalid, m_axi.bready, m_axi.rready}), 0);
    chk("t6_idle_after_reset", 32'({cmd_ready, busy, done, error}), 32'b1000);
    chk("t6_err_code_reset", 32'(err_code), 0);
    exp_q.delete();
    tick(2);
    chk("t6_write7_dropped", 32'(wr_n - wr0), 6);
    aw_lat = 0;
    snap(); done_at = rd_n + 1;
    push_layer(32'hC0, 12); send_cmd(32'hC0); wait_end("t6"); tick(3);
    end_checks("t6", 12, 1, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
